// File: rtl/bridge_pkg.sv
// bridge_pkg: states, ASCII codes and hex helpers shared by bridge_rx and bridge_tx.
package bridge_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WRITE = ST_WRITE
    } state_t;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam logic [3:0] RD_NIBBLES = 4'd4;
    localparam logic [3:0] WR_NIBBLES = 4'd8;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters have bit 6 set and low nibble 1..6, so adding 9 gives 10..15.
    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        return c[3:0] + (c[6] ? 4'd9 : 4'd0);
    endfunction

endpackage

// File: rtl/bridge_rx.sv
// bridge_rx: parses ASCII "Raaaa"/"Waaaadddd" + CR/LF into one-cycle 16-bit bus transactions.
// Optional idle timeout on partial messages is enabled by defining BRIDGE_RX_TIMEOUT_EN.
module bridge_rx
    import bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [15:0] addr_o,
    output logic [15:0] data_o,
    output logic        rw_o,
    output logic        valid_o
);

    state_t      state;
    logic [3:0]  nib_cnt;
    logic [31:0] shift_buf;
    logic [3:0]  need;
    logic        is_term;

    assign need    = (state == WRITE) ? WR_NIBBLES : RD_NIBBLES;
    assign is_term = (data_i == ASCII_CR) || (data_i == ASCII_LF);

`ifdef BRIDGE_RX_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] idle_cnt;
`else
    // TIMEOUT_CYCLES has no effect without the idle counter.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nib_cnt   <= '0;
            shift_buf <= '0;
            addr_o    <= '0;
            data_o    <= '0;
            rw_o      <= 1'b0;
            valid_o   <= 1'b0;
`ifdef BRIDGE_RX_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            valid_o <= 1'b0;
            if (valid_i) begin
`ifdef BRIDGE_RX_TIMEOUT_EN
                idle_cnt <= '0;
`endif
                // R/W always opens a fresh message, even mid-message (resync).
                if (data_i == ASCII_R || data_i == ASCII_W) begin
                    state     <= (data_i == ASCII_R) ? READ : WRITE;
                    nib_cnt   <= '0;
                    shift_buf <= '0;
                end else if (state != IDLE) begin
                    if (is_term) begin
                        if (nib_cnt == need) begin
                            valid_o <= 1'b1;
                            rw_o    <= (state == WRITE);
                            if (state == WRITE) begin
                                addr_o <= shift_buf[31:16];
                                data_o <= shift_buf[15:0];
                            end else begin
                                addr_o <= shift_buf[15:0];
                                data_o <= '0;
                            end
                        end
                        state     <= IDLE;
                        nib_cnt   <= '0;
                        shift_buf <= '0;
                    end else if (is_hex(data_i) && nib_cnt != need) begin
                        shift_buf <= {shift_buf[27:0], hex_to_nibble(data_i)};
                        nib_cnt   <= nib_cnt + 4'd1;
                    end else begin
                        state     <= IDLE;
                        nib_cnt   <= '0;
                        shift_buf <= '0;
                    end
                end
            end
`ifdef BRIDGE_RX_TIMEOUT_EN
            else if (state != IDLE) begin
                idle_cnt <= idle_cnt + 16'd1;
                if (idle_cnt + 16'd1 == TIMEOUT_LIM) begin
                    state     <= IDLE;
                    nib_cnt   <= '0;
                    shift_buf <= '0;
                    idle_cnt  <= '0;
                end
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end

endmodule
